// File: rtl/sub32_seq_if.sv
// Handshake and data bus of the sequential 32-bit subtractor.
// The master drives the request and operands; the slave returns result and flags.
interface sub32_seq_if;
   logic        start;
   logic [31:0] in1;
   logic [31:0] in2;
   logic [31:0] out_data;
   logic        borrow;
   logic        zero;
   logic        negative;
   logic        overflow;
   logic        busy;
   logic        done;

   modport master (
      output start, in1, in2,
      input  out_data, borrow, zero, negative, overflow, busy, done
   );

   modport slave (
      input  start, in1, in2,
      output out_data, borrow, zero, negative, overflow, busy, done
   );
endinterface

// File: rtl/sub32_seq.sv
// Multi-cycle 32-bit subtractor: in1 - in2 as four 8-bit slices with a rippled borrow.
// Result and flags are registered at completion and held until the next one.
module sub32_seq (
   input logic       clk,
   input logic       rst_n,
   sub32_seq_if.slave bus
);

   typedef enum logic {IDLE, CALC} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  cnt;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] acc;
   logic        brw;

   logic [7:0]  a_sl;
   logic [7:0]  b_sl;
   logic [8:0]  slice_diff;
   logic [31:0] full;
   logic        accept;
   logic        last;

   logic [31:0] res_q;
   logic        borrow_q;
   logic        zero_q;
   logic        neg_q;
   logic        ovf_q;
   logic        done_q;

   always_comb begin
      a_sl       = a[{cnt, 3'b000} +: 8];
      b_sl       = b[{cnt, 3'b000} +: 8];
      slice_diff = {1'b0, a_sl} - {1'b0, b_sl} - {8'd0, brw};
      // slice 3 completes in this cycle, so the upper byte comes straight from the subtractor
      full       = {slice_diff[7:0], acc[23:0]};
      accept     = (state == IDLE) && bus.start;
      last       = (state == CALC) && (cnt == 2'd3);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = CALC;
         CALC:    if (cnt == 2'd3) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         a        <= '0;
         b        <= '0;
         acc      <= '0;
         brw      <= 1'b0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= last;
         if (accept) begin
            a   <= bus.in1;
            b   <= bus.in2;
            cnt <= '0;
            brw <= 1'b0;
         end else if (state == CALC) begin
            acc[{cnt, 3'b000} +: 8] <= slice_diff[7:0];
            brw                     <= slice_diff[8];
            cnt                     <= cnt + 2'd1;
         end
         if (last) begin
            res_q    <= full;
            borrow_q <= slice_diff[8];
            zero_q   <= (full == '0);
            neg_q    <= full[31];
            ovf_q    <= (a[31] != b[31]) && (full[31] != a[31]);
         end
      end
   end

   assign bus.out_data = res_q;
   assign bus.borrow   = borrow_q;
   assign bus.zero     = zero_q;
   assign bus.negative = neg_q;
   assign bus.overflow = ovf_q;
   assign bus.busy     = (state == CALC);
   assign bus.done     = done_q;

endmodule

// File: tb/tb_sub32_seq.sv
// Self-checking bench for sub32_seq: directed vector table, random operands against an
// arithmetic reference, and hand-written handshake/reset sequences.
module tb_sub32_seq;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   sub32_seq_if bus ();

   sub32_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] in1;
      logic [31:0] in2;
      logic [31:0] res;
      logic [3:0]  flags;   // {borrow, zero, negative, overflow}
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] flags_now();
      return {bus.borrow, bus.zero, bus.negative, bus.overflow};
   endfunction

   // Reference built from whole-word arithmetic rather than slices.
   function automatic vec_t model(input logic [31:0] x, input logic [31:0] y);
      vec_t   v;
      longint sd;
      v.in1 = x;
      v.in2 = y;
      v.res = x - y;
      sd    = longint'($signed(x)) - longint'($signed(y));
      v.flags[3] = (x < y);
      v.flags[2] = (v.res == 32'd0);
      v.flags[1] = v.res[31];
      v.flags[0] = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      return v;
   endfunction

   // Issue one operation, scramble the inputs after capture, and wait for done.
   task automatic do_op(input vec_t v, input string name);
      int lat;
      @(negedge clk);
      bus.start = 1'b1;
      bus.in1   = v.in1;
      bus.in2   = v.in2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.in1   = $urandom;
      bus.in2   = $urandom;
      chk({name, " busy after accept"}, {31'd0, bus.busy}, 32'd1);
      lat = 0;
      while (!bus.done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({name, " latency"}, lat, 32'd4);
      chk({name, " out_data"}, bus.out_data, v.res);
      chk({name, " flags"}, {28'd0, flags_now()}, {28'd0, v.flags});
      chk({name, " busy at done"}, {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #1;
      chk({name, " done width"}, {31'd0, bus.done}, 32'd0);
      chk({name, " hold"}, bus.out_data, v.res);
   endtask

   initial begin
      int   dones;
      int   t_prev;
      int   gap;
      vec_t v;

      n_checks = 0;
      n_fail   = 0;

      vecs[0] = '{in1: 32'd5,          in2: 32'd7,          res: 32'hFFFFFFFE, flags: 4'b1010};
      vecs[1] = '{in1: 32'h80000000,   in2: 32'd1,          res: 32'h7FFFFFFF, flags: 4'b0001};
      vecs[2] = '{in1: 32'h00010000,   in2: 32'h0000FFFF,   res: 32'h00000001, flags: 4'b0000};
      vecs[3] = '{in1: 32'h12345678,   in2: 32'h12345678,   res: 32'h00000000, flags: 4'b0100};
      vecs[4] = '{in1: 32'h7FFFFFFF,   in2: 32'hFFFFFFFF,   res: 32'h80000000, flags: 4'b1011};

      bus.start = 1'b0;
      bus.in1   = '0;
      bus.in2   = '0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset out_data", bus.out_data, 32'd0);
      chk("reset flags", {28'd0, flags_now()}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.busy || bus.done) dones++;
      end
      chk("idle busy/done stay low", dones, 32'd0);

      for (int i = 0; i < 5; i++) do_op(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         logic [31:0] x;
         logic [31:0] y;
         x = $urandom;
         y = (i % 8 == 0) ? x : $urandom;
         if (i % 8 == 1) y = x + 32'd1;
         do_op(model(x, y), $sformatf("rnd%0d", i));
      end

      // Start pulsed while the 5-7 operation is in flight must be ignored.
      @(negedge clk);
      bus.start = 1'b1;
      bus.in1   = 32'd5;
      bus.in2   = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.in1   = 32'd9;
      bus.in2   = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
         if (i > 4 && bus.busy) dones += 10;
      end
      chk("busy start done count", dones, 32'd1);
      chk("busy start result", bus.out_data, 32'hFFFFFFFE);

      // Held start: back-to-back operations, done pulses five cycles apart.
      @(negedge clk);
      bus.start = 1'b1;
      bus.in1   = 32'd100;
      bus.in2   = 32'd1;
      dones  = 0;
      t_prev = -1;
      gap    = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            if (t_prev >= 0) gap = i - t_prev;
            t_prev = i;
            dones++;
         end
      end
      bus.start = 1'b0;
      chk("held start done gap", gap, 32'd5);
      chk("held start done count", dones, 32'd3);
      chk("held start result", bus.out_data, 32'd99);
      repeat (6) @(posedge clk);

      // Reset after edge k+2 aborts the operation without a done.
      @(negedge clk);
      bus.start = 1'b1;
      bus.in1   = 32'd1;
      bus.in2   = 32'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset busy", {31'd0, bus.busy}, 32'd0);
      chk("async reset out_data", bus.out_data, 32'd0);
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) dones++;
      end
      chk("aborted op no done", dones, 32'd0);
      v = model(32'd10, 32'd3);
      chk("model 10-3", v.res, 32'd7);
      do_op(v, "after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
